pool_stream: RTL and testbench

POOL_STREAM -- requirements
Module: pool_stream

---
 rtl/pool_stream.sv | 110 +++++++++++
 tb/tb_pool_stream.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_stream.sv
// Streaming max/average pooling over K-beat windows, CH channels per beat.
// One registered result per window, with a valid/ready handshake on both sides.
module pool_stream #(
  parameter int DW     = 8,
  parameter int CH     = 4,
  parameter int K      = 2,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [CH*DW-1:0] m_data,
  input  logic             m_valid,
  input  logic             m_last,
  output logic             m_ready,
  output logic [CH*DW-1:0] s_data,
  output logic             s_valid,
  input  logic             s_ready
);

  localparam int LK = $clog2(K);
  localparam int AW = DW + LK;

  logic [LK-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [AW-1:0]    acc_q [CH];
  logic [AW-1:0]    acc_d [CH];
  logic [CH*DW-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic             first;
  logic             cur_mode;
  logic             close;
  logic [AW-1:0]    nxt_w [CH];
  logic [DW-1:0]    res_w [CH];

  assign accept   = m_valid & m_ready;
  assign first    = (cnt_q == '0);
  assign cur_mode = first ? mode : mode_q;
  assign close    = accept & (m_last | (cnt_q == LK'(K - 1)));

  // Accumulators are DW+LK wide so a full window of sums cannot overflow;
  // in max mode they simply hold the extended running maximum.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DW-1:0] beat;
    logic [AW-1:0] ext;
    logic          gt;

    assign beat = m_data[c*DW +: DW];
    assign ext  = (SIGNED != 0) ? {{LK{beat[DW-1]}}, beat} : {{LK{1'b0}}, beat};
    assign gt   = (SIGNED != 0) ? ($signed(ext) > $signed(acc_q[c])) : (ext > acc_q[c]);
    assign nxt_w[c] = first    ? ext :
                      cur_mode ? (acc_q[c] + ext) :
                      (gt ? ext : acc_q[c]);
    // Taking bits [LK +: DW] is the floor divide by K for both signednesses.
    assign res_w[c] = cur_mode ? nxt_w[c][LK +: DW] : nxt_w[c][DW-1:0];
  end

  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && s_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (first) begin
        mode_d = mode;
      end
      for (int c = 0; c < CH; c++) begin
        acc_d[c] = nxt_w[c];
      end
      cnt_d = close ? '0 : cnt_q + LK'(1);
    end
    if (close) begin
      valid_d = 1'b1;
      for (int c = 0; c < CH; c++) begin
        data_d[c*DW +: DW] = res_w[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      for (int c = 0; c < CH; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign m_ready = ~valid_q | s_ready | ~rst_n;
  assign s_data  = data_q;
  assign s_valid = valid_q;

endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream: four instances (K/SIGNED variants),
// directed windows with hand-computed results plus a random stream checked by a model.
module tb_pool_stream;

  logic        clk;
  logic        rstN;
  logic [31:0] mData  [4];
  logic        mValid [4];
  logic        mLast  [4];
  logic        modeS  [4];
  logic        sReady [4];
  logic        mReady [4];
  logic        sValid [4];
  logic [31:0] sData  [4];

  int   total = 0;
  int   bad   = 0;
  logic rndReady = 1'b0;

  typedef struct {
    int          d;
    logic [31:0] v;
  } exp_t;

  exp_t        expQ [$];
  logic [31:0] handQ [$];
  logic [31:0] winBuf [4][16];
  int          winCnt [4];
  logic        winMode [4];
  logic        prevHold [4];
  logic [31:0] prevData [4];
  exp_t        monEntry;

  // dut0: K=2 unsigned, dut1: K=4 signed, dut2: K=4 unsigned, dut3: K=8 signed
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int KG = (g == 0) ? 2 : ((g == 3) ? 8 : 4);
    localparam int SG = (g == 1 || g == 3) ? 1 : 0;
    pool_stream #(.DW(8), .CH(4), .K(KG), .SIGNED(SG)) u_dut (
      .clk     (clk),
      .rst_n   (rstN),
      .mode    (modeS[g]),
      .m_data  (mData[g]),
      .m_valid (mValid[g]),
      .m_last  (mLast[g]),
      .m_ready (mReady[g]),
      .s_data  (sData[g]),
      .s_valid (sValid[g]),
      .s_ready (sReady[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int kOf(input int d);
    return (d == 0) ? 2 : ((d == 3) ? 8 : 4);
  endfunction

  function automatic bit sgnOf(input int d);
    return (d == 1 || d == 3);
  endfunction

  // Reference pooling over the beats collected for the current window.
  function automatic logic [31:0] poolRef(input int d);
    logic [31:0] r;
    logic [7:0]  b;
    int          acc;
    int          v;
    int          lk;
    lk = (kOf(d) == 2) ? 1 : ((kOf(d) == 4) ? 2 : 3);
    r  = '0;
    for (int c = 0; c < 4; c++) begin
      acc = 0;
      for (int i = 0; i < winCnt[d]; i++) begin
        b = winBuf[d][i][c*8 +: 8];
        if (sgnOf(d)) v = int'($signed(b));
        else          v = int'(b);
        if (winMode[d]) acc = acc + v;
        else if (i == 0 || v > acc) acc = v;
      end
      if (winMode[d]) acc = acc >>> lk;
      r[c*8 +: 8] = acc[7:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic modelAccept(input int d, input logic [31:0] data, input logic last, input logic md);
    exp_t e;
    winBuf[d][winCnt[d]] = data;
    if (winCnt[d] == 0) winMode[d] = md;
    winCnt[d]++;
    if (last || winCnt[d] == kOf(d)) begin
      e.d = d;
      e.v = (handQ.size() != 0) ? handQ.pop_front() : poolRef(d);
      expQ.push_back(e);
      winCnt[d] = 0;
    end
  endtask

  task automatic applyStimulus(input int d, input logic [31:0] data, input logic last, input logic md);
    bit done;
    done = 1'b0;
    @(negedge clk);
    mData[d]  = data;
    mValid[d] = 1'b1;
    mLast[d]  = last;
    modeS[d]  = md;
    for (int t = 0; t < 60 && !done; t++) begin
      #1;
      checkOutput("m_ready rule", {31'b0, mReady[d]}, {31'b0, ~sValid[d] | sReady[d]});
      if (mReady[d]) begin
        modelAccept(d, data, last, md);
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept timeout dut%0d got=stuck exp=accepted", d);
    end
  endtask

  task automatic endStream(input int d);
    @(negedge clk);
    mValid[d] = 1'b0;
    mLast[d]  = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    for (int d = 0; d < 4; d++) begin
      mValid[d] = 1'b0;
      mLast[d]  = 1'b0;
      sReady[d] = 1'b0;
      winCnt[d] = 0;
    end
    expQ.delete();
    handQ.delete();
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 4; d++) checkOutput($sformatf("m_ready in reset dut%0d", d), {31'b0, mReady[d]}, 32'd1);
    @(negedge clk);
    rstN = 1'b1;
    for (int d = 0; d < 4; d++) sReady[d] = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("reset s_valid dut%0d", d), {31'b0, sValid[d]}, 32'd0);
      checkOutput($sformatf("reset s_data dut%0d", d), sData[d], 32'd0);
      checkOutput($sformatf("m_ready after reset dut%0d", d), {31'b0, mReady[d]}, 32'd1);
    end
  endtask

  task automatic waitDrain(input string name);
    for (int t = 0; t < 100 && expQ.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput({"drain ", name}, expQ.size(), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  always begin
    @(negedge clk);
    #2;
    if (!rstN) begin
      for (int d = 0; d < 4; d++) prevHold[d] = 1'b0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (prevHold[d]) begin
          checkOutput($sformatf("hold s_valid dut%0d", d), {31'b0, sValid[d]}, 32'd1);
          checkOutput($sformatf("hold s_data dut%0d", d), sData[d], prevData[d]);
        end
        if (sValid[d] && sReady[d]) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected result dut%0d got=%h exp=none", d, sData[d]);
          end else begin
            monEntry = expQ.pop_front();
            if (monEntry.d != d) begin
              total++;
              bad++;
              $display("[TB] FAIL result source got=dut%0d exp=dut%0d", d, monEntry.d);
            end else begin
              checkOutput($sformatf("result dut%0d", d), sData[d], monEntry.v);
            end
          end
        end
        prevHold[d] = sValid[d] & ~sReady[d];
        prevData[d] = sData[d];
      end
    end
  end

  always begin
    @(negedge clk);
    if (rndReady) begin
      for (int d = 0; d < 4; d++) sReady[d] = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] oneBeat [3];

  initial begin
    rstN = 1'b0;
    for (int d = 0; d < 4; d++) begin
      mData[d] = '0; mValid[d] = 1'b0; mLast[d] = 1'b0; modeS[d] = 1'b0; sReady[d] = 1'b1;
      winCnt[d] = 0; winMode[d] = 1'b0;
    end
    doReset();

    // Max pooling, K=2, then check the one-cycle result latency
    handQ.push_back(32'h08FF0905);
    applyStimulus(0, 32'h07C80903, 1'b0, 1'b0);
    applyStimulus(0, 32'h08FF0105, 1'b0, 1'b0);
    endStream(0);
    #2;
    checkOutput("latency s_valid", {31'b0, sValid[0]}, 32'd1);

    // Average, K=2; mode change on second beat must be ignored
    handQ.push_back(32'h00FF140A);
    applyStimulus(0, 32'h00FF140A, 1'b0, 1'b1);
    applyStimulus(0, 32'h01FF150B, 1'b0, 1'b0);

    // Back-to-back one-beat windows: retire and load in the same cycle
    oneBeat[0] = 32'hAA55AA55;
    oneBeat[1] = 32'h5B6C7D8E;
    oneBeat[2] = 32'hC3000FF0;
    for (int i = 0; i < 3; i++) begin
      handQ.push_back(oneBeat[i]);
      applyStimulus(0, oneBeat[i], 1'b1, 1'b0);
    end
    endStream(0);
    waitDrain("k2 directed");

    // Signed average K=4: ch0 -4,-3,-2,-2 -> -3
    handQ.push_back(32'h00807FFD);
    applyStimulus(1, 32'h01807FFC, 1'b0, 1'b1);
    applyStimulus(1, 32'h00807FFD, 1'b0, 1'b0);
    applyStimulus(1, 32'h00807FFE, 1'b0, 1'b0);
    applyStimulus(1, 32'h00807FFE, 1'b0, 1'b1);
    // Signed max K=4
    handQ.push_back(32'h7F80FD05);
    applyStimulus(1, 32'h7F8080FF, 1'b0, 1'b0);
    applyStimulus(1, 32'hFF80F905, 1'b0, 1'b1);
    applyStimulus(1, 32'h0080FD9C, 1'b0, 1'b1);
    applyStimulus(1, 32'h0180CE03, 1'b0, 1'b1);
    endStream(1);
    waitDrain("k4 signed");

    // Early close in avg still divides by K; next window starts fresh
    handQ.push_back(32'h00017F4B);
    applyStimulus(2, 32'h0004FF64, 1'b0, 1'b1);
    applyStimulus(2, 32'h0003FFC8, 1'b1, 1'b1);
    handQ.push_back(32'h04040404);
    applyStimulus(2, 32'h01010101, 1'b0, 1'b0);
    applyStimulus(2, 32'h04040404, 1'b0, 1'b0);
    applyStimulus(2, 32'h02020202, 1'b0, 1'b0);
    applyStimulus(2, 32'h03030303, 1'b0, 1'b0);
    handQ.push_back(32'h043F0201);
    applyStimulus(2, 32'h10FF0807, 1'b1, 1'b1);
    handQ.push_back(32'h12345678);
    applyStimulus(2, 32'h12345678, 1'b1, 1'b0);
    endStream(2);
    waitDrain("k4 unsigned");

    // Output stall for 5 cycles while the stream keeps coming
    handQ.push_back(32'h05060708);
    handQ.push_back(32'h22222222);
    handQ.push_back(32'h09090909);
    @(negedge clk);
    sReady[0] = 1'b0;
    fork
      begin
        for (int t = 0; t < 20 && !sValid[0]; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        sReady[0] = 1'b1;
      end
      begin
        applyStimulus(0, 32'h01020304, 1'b0, 1'b0);
        applyStimulus(0, 32'h05060708, 1'b0, 1'b0);
        applyStimulus(0, 32'h11111111, 1'b0, 1'b0);
        applyStimulus(0, 32'h22222222, 1'b0, 1'b0);
        applyStimulus(0, 32'h09090909, 1'b0, 1'b0);
        applyStimulus(0, 32'h03030303, 1'b0, 1'b0);
      end
    join
    endStream(0);
    waitDrain("stall");

    // Reset mid-window discards the partial beat
    applyStimulus(0, 32'h63636363, 1'b0, 1'b0);
    endStream(0);
    doReset();
    handQ.push_back(32'h14141414);
    applyStimulus(0, 32'h0A0A0A0A, 1'b0, 1'b0);
    applyStimulus(0, 32'h14141414, 1'b0, 1'b0);
    endStream(0);
    waitDrain("reset window");

    // Random streams on K=2 unsigned and K=8 signed with random backpressure
    for (int pass = 0; pass < 2; pass++) begin
      int d;
      d = (pass == 0) ? 0 : 3;
      rndReady = 1'b1;
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 3) == 0) endStream(d);
        applyStimulus(d, $urandom, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end
      endStream(d);
      rndReady = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) sReady[k] = 1'b1;
      waitDrain($sformatf("random dut%0d", d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
